// File: rtl/ext_bus_pkg.sv
// Shared types and helpers for the external-bus controller: FSM state encoding,
// wait-counter width and the channel-select width function.
package ext_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2,
    ERR    = 2'd3
  } bus_state_e;

  localparam int WAIT_CNT_W = 8;

  // A single channel still needs one select bit, so clamp to at least 1.
  function automatic int ch_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_wait_timer.sv
// Wait-state counter: cleared when an access starts, counts cycles without an
// acknowledge and flags expiry on the cycle that would reach WAIT_MAX.
module bus_wait_timer
  import ext_bus_pkg::*;
#(
  parameter int WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [WAIT_CNT_W-1:0] LAST = WAIT_CNT_W'(WAIT_MAX - 1);

  logic [WAIT_CNT_W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= count_q + 1'b1;
    end
  end

  // Expiry is flagged while counting the final permitted wait cycle, so the
  // controller leaves ACCESS on the same edge the count reaches WAIT_MAX.
  assign expire = en && (count_q == LAST);

endmodule

// File: rtl/ext_bus_ctrl.sv
// External-bus controller: one outstanding CPU transaction routed to one of
// NUM_CH memory channels with per-channel strobes, wait states and timeout.
module ext_bus_ctrl
  import ext_bus_pkg::*;
#(
  parameter  int DATA_W   = 16,
  parameter  int ADDR_W   = 8,
  parameter  int NUM_CH   = 2,
  parameter  int WAIT_MAX = 15,
  localparam int CH_W     = ch_width(NUM_CH)
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_req,
  input  logic                     i_we,
  input  logic [CH_W-1:0]          i_ch_sel,
  input  logic [ADDR_W-1:0]        i_addr,
  input  logic [DATA_W-1:0]        i_wdata,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_err,
  output logic [DATA_W-1:0]        o_rdata,
  output logic [ADDR_W-1:0]        o_mem_addr,
  output logic [DATA_W-1:0]        o_mem_wdata,
  output logic [NUM_CH-1:0]        o_mem_rd,
  output logic [NUM_CH-1:0]        o_mem_wr,
  input  logic [NUM_CH*DATA_W-1:0] i_mem_rdata,
  input  logic [NUM_CH-1:0]        i_mem_ack
);

  // Handshake: a request is taken only when i_req is high in IDLE; the channel
  // strobe then stays high every ACCESS cycle until the selected channel's
  // i_mem_ack is sampled high (transfer completes on that edge) or the wait
  // budget runs out. Requests seen while busy are dropped, never queued.

  localparam int               SEL_W    = $clog2(NUM_CH * DATA_W);
  localparam logic [CH_W:0]    CH_LIMIT = (CH_W + 1)'(NUM_CH);

  bus_state_e state, state_n;

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              we_q;
  logic [CH_W-1:0]   ch_q;

  logic              ch_ok;
  logic              accept;
  logic              ack_sel;
  logic              in_access;
  logic              tmr_clr;
  logic              tmr_en;
  logic              tmr_expire;
  logic [NUM_CH-1:0] strobe;
  logic [SEL_W-1:0]  rd_base;
  logic [DATA_W-1:0] rd_sel;

  assign ch_ok     = ({1'b0, i_ch_sel} < CH_LIMIT);
  assign in_access = (state == ACCESS);
  assign ack_sel   = i_mem_ack[ch_q];
  assign strobe    = NUM_CH'(1) << ch_q;
  assign rd_base   = SEL_W'(32'(ch_q) * DATA_W);
  assign rd_sel    = i_mem_rdata[rd_base +: DATA_W];

  bus_wait_timer #(
    .WAIT_MAX (WAIT_MAX)
  ) u_wait_timer (
    .clk    (i_clk),
    .rst_n  (i_rst_n),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .expire (tmr_expire)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    tmr_clr = 1'b0;
    tmr_en  = 1'b0;
    case (state)
      IDLE: begin
        if (i_req) begin
          if (ch_ok) begin
            state_n = ACCESS;
            accept  = 1'b1;
            tmr_clr = 1'b1;
          end else begin
            state_n = ERR;
          end
        end
      end
      ACCESS: begin
        // An ack on the final wait cycle still completes the transfer.
        if (ack_sel) begin
          state_n = DONE;
        end else begin
          tmr_en = 1'b1;
          if (tmr_expire) begin
            state_n = ERR;
          end
        end
      end
      DONE:    state_n = IDLE;
      ERR:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Request fields are captured once so the CPU may move on after acceptance.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      ch_q    <= '0;
    end else if (accept) begin
      addr_q  <= i_addr;
      wdata_q <= i_wdata;
      we_q    <= i_we;
      ch_q    <= i_ch_sel;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rdata_q <= '0;
    end else if (in_access && ack_sel && !we_q) begin
      rdata_q <= rd_sel;
    end
  end

  // Strobes decode straight from the state register so reset clears them
  // without waiting for a clock edge.
  assign o_mem_rd    = (in_access && !we_q) ? strobe : '0;
  assign o_mem_wr    = (in_access &&  we_q) ? strobe : '0;
  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wdata_q;
  assign o_rdata     = rdata_q;
  assign o_busy      = (state != IDLE);
  assign o_done      = (state == DONE);
  assign o_err       = (state == ERR);

  a_done_err_excl: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(o_done && o_err));
  a_strobe_onehot: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    $onehot0({o_mem_rd, o_mem_wr}));
  a_strobe_busy: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (|{o_mem_rd, o_mem_wr}) |-> o_busy);

endmodule

// File: tb/tb_ext_bus_ctrl.sv
// Bench for ext_bus_ctrl: directed transactions with a cycle-timeline model,
// plus a 3-channel instance for invalid-channel and short-timeout cases.
module tb_ext_bus_ctrl;

  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 8;
  localparam int NUM_CH    = 2;
  localparam int WAIT_MAX  = 15;
  localparam int CH_W      = 1;
  localparam int NUM_CH3   = 3;
  localparam int WAIT_MAX3 = 4;
  localparam int CH_W3     = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- main DUT (2 channels) ----------------
  logic                     req, we;
  logic [CH_W-1:0]          ch_sel;
  logic [ADDR_W-1:0]        addr;
  logic [DATA_W-1:0]        wdata;
  logic                     busy, done, err;
  logic [DATA_W-1:0]        rdata;
  logic [ADDR_W-1:0]        mem_addr;
  logic [DATA_W-1:0]        mem_wdata;
  logic [NUM_CH-1:0]        mem_rd, mem_wr;
  logic [NUM_CH*DATA_W-1:0] mem_rdata;
  logic [NUM_CH-1:0]        mem_ack;

  ext_bus_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_CH(NUM_CH), .WAIT_MAX(WAIT_MAX)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_we(we), .i_ch_sel(ch_sel),
    .i_addr(addr), .i_wdata(wdata), .o_busy(busy), .o_done(done), .o_err(err),
    .o_rdata(rdata), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .o_mem_rd(mem_rd), .o_mem_wr(mem_wr), .i_mem_rdata(mem_rdata), .i_mem_ack(mem_ack)
  );

  // ---------------- second DUT (3 channels, short timeout) ----------------
  logic                      c3_req, c3_we;
  logic [CH_W3-1:0]          c3_ch;
  logic [ADDR_W-1:0]         c3_addr;
  logic [DATA_W-1:0]         c3_wdata;
  logic                      c3_busy, c3_done, c3_err;
  logic [DATA_W-1:0]         c3_rdata;
  logic [ADDR_W-1:0]         c3_mem_addr;
  logic [DATA_W-1:0]         c3_mem_wdata;
  logic [NUM_CH3-1:0]        c3_rd, c3_wr;
  logic [NUM_CH3*DATA_W-1:0] c3_mem_rdata;
  logic [NUM_CH3-1:0]        c3_ack;

  ext_bus_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_CH(NUM_CH3), .WAIT_MAX(WAIT_MAX3)
  ) dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(c3_req), .i_we(c3_we), .i_ch_sel(c3_ch),
    .i_addr(c3_addr), .i_wdata(c3_wdata), .o_busy(c3_busy), .o_done(c3_done),
    .o_err(c3_err), .o_rdata(c3_rdata), .o_mem_addr(c3_mem_addr),
    .o_mem_wdata(c3_mem_wdata), .o_mem_rd(c3_rd), .o_mem_wr(c3_wr),
    .i_mem_rdata(c3_mem_rdata), .i_mem_ack(c3_ack)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  // Expected outputs of the main DUT for the current cycle.
  logic              e_on = 1'b0;
  logic              e_busy, e_done, e_err;
  logic [NUM_CH-1:0] e_rd, e_wr;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata, m_rdata;

  int obs_done = 0;
  int obs_err  = 0;
  int obs_strb = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Single compare process: every falling edge, main DUT against the model.
  always @(negedge clk) begin
    if (e_on) begin
      chk("busy",      32'(busy),      32'(e_busy));
      chk("done",      32'(done),      32'(e_done));
      chk("err",       32'(err),       32'(e_err));
      chk("mem_rd",    32'(mem_rd),    32'(e_rd));
      chk("mem_wr",    32'(mem_wr),    32'(e_wr));
      chk("mem_addr",  32'(mem_addr),  32'(m_addr));
      chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
      chk("rdata",     32'(rdata),     32'(m_rdata));
    end
    if (done === 1'b1) obs_done++;
    if (err === 1'b1) obs_err++;
    if ((|mem_rd) || (|mem_wr)) obs_strb++;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_idle();
    e_busy = 1'b0; e_done = 1'b0; e_err = 1'b0; e_rd = '0; e_wr = '0;
  endtask

  task automatic mem_idle();
    mem_ack   = '0;
    mem_rdata = {16'h5A5A, 16'hA5A5};
  endtask

  task automatic clr_obs();
    obs_done = 0; obs_err = 0; obs_strb = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      req = 1'b0;
      mem_idle();
      exp_idle();
    end
  endtask

  // One transaction on the main DUT. ack_k = wait cycles before the ack
  // (-1 = never acked). stray adds foreign acks and busy-time requests.
  task automatic txn(input logic we_i, input logic [CH_W-1:0] ch, input logic [ADDR_W-1:0] a,
                     input logic [DATA_W-1:0] wd, input int ack_k,
                     input logic [DATA_W-1:0] rd_val, input bit stray);
    int len;
    bit acked;
    int own, oth;
    logic [NUM_CH-1:0] sb;
    acked = (ack_k >= 0) && (ack_k < WAIT_MAX);
    len   = acked ? ack_k + 1 : WAIT_MAX;
    sb    = 2'b01 << ch;
    own   = int'(ch) * DATA_W;
    oth   = (1 - int'(ch)) * DATA_W;

    step();
    req = 1'b1; we = we_i; ch_sel = ch; addr = a; wdata = wd;
    mem_idle();
    if (stray) mem_ack = sb;
    exp_idle();

    for (int j = 0; j < len; j++) begin
      step();
      req    = stray ? ((j % 2) == 0) : 1'b0;
      we     = ~we_i;
      ch_sel = ~ch;
      addr   = ~a;
      wdata  = ~wd;
      mem_idle();
      if (stray) begin
        mem_ack = ~sb;
        mem_rdata[oth +: DATA_W] = 16'hDEAD;
      end
      if (acked && j == ack_k) begin
        mem_ack = mem_ack | sb;
        mem_rdata[own +: DATA_W] = rd_val;
      end
      m_addr  = a;
      m_wdata = wd;
      e_busy = 1'b1; e_done = 1'b0; e_err = 1'b0;
      e_rd = we_i ? '0 : sb;
      e_wr = we_i ? sb : '0;
    end

    step();
    req = stray;
    mem_idle();
    if (stray) begin
      mem_ack = sb;
      mem_rdata[own +: DATA_W] = 16'hBAD0;
    end
    if (acked && !we_i) m_rdata = rd_val;
    e_busy = 1'b1; e_done = acked; e_err = !acked; e_rd = '0; e_wr = '0;
  endtask

  // ---------------- 3-channel directed checks ----------------
  task automatic c3_idle_inputs();
    c3_req = 1'b0; c3_we = 1'b0; c3_ch = '0; c3_addr = '0; c3_wdata = '0;
    c3_ack = '0; c3_mem_rdata = {16'h2222, 16'h1111, 16'h0000};
  endtask

  task automatic run_c3();
    // invalid channel
    step(); c3_req = 1'b1; c3_ch = 2'd3; c3_addr = 8'h99;
    chk("c3_inv_pre_rd", 32'(c3_rd | c3_wr), 0);
    step(); c3_req = 1'b0; c3_ch = 2'd0;
    chk("c3_inv_err", 32'(c3_err), 1);
    chk("c3_inv_busy", 32'(c3_busy), 1);
    chk("c3_inv_strobe", 32'(c3_rd | c3_wr), 0);
    chk("c3_inv_done", 32'(c3_done), 0);
    step();
    chk("c3_inv_err_end", 32'(c3_err), 0);
    chk("c3_inv_busy_end", 32'(c3_busy), 0);
    chk("c3_inv_strobe_end", 32'(c3_rd | c3_wr), 0);

    // zero-wait read on the top channel, with a foreign ack on ch0
    step(); c3_req = 1'b1; c3_ch = 2'd2; c3_we = 1'b0; c3_addr = 8'h33;
    step(); c3_req = 1'b0; c3_ch = 2'd0; c3_addr = 8'h00;
    chk("c3_rd_strobe", 32'(c3_rd), 32'h4);
    chk("c3_rd_addr", 32'(c3_mem_addr), 32'h33);
    c3_ack = 3'b101;
    c3_mem_rdata = {16'h7777, 16'h1111, 16'hDEAD};
    step(); c3_ack = '0; c3_mem_rdata = {16'h2222, 16'h1111, 16'h0000};
    chk("c3_rd_done", 32'(c3_done), 1);
    chk("c3_rd_data", 32'(c3_rdata), 32'h7777);
    chk("c3_rd_strobe_off", 32'(c3_rd), 0);
    step();
    chk("c3_rd_idle", 32'(c3_busy), 0);

    // write timeout with WAIT_MAX3 wait cycles
    step(); c3_req = 1'b1; c3_ch = 2'd1; c3_we = 1'b1; c3_wdata = 16'h5555;
    for (int i = 0; i < WAIT_MAX3; i++) begin
      step(); c3_req = 1'b0;
      chk("c3_to_wr", 32'(c3_wr), 32'h2);
      chk("c3_to_err_low", 32'(c3_err), 0);
    end
    step();
    chk("c3_to_err", 32'(c3_err), 1);
    chk("c3_to_wr_off", 32'(c3_wr), 0);
    chk("c3_to_rdata_kept", 32'(c3_rdata), 32'h7777);
    step();
    chk("c3_to_idle", 32'(c3_busy), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0;
    req = 1'b0; we = 1'b0; ch_sel = '0; addr = '0; wdata = '0;
    mem_idle();
    c3_idle_inputs();
    exp_idle();
    m_addr = '0; m_wdata = '0; m_rdata = '0;
    e_on = 1'b1;

    repeat (3) step();
    rst_n = 1'b1;
    idle(2);

    run_c3();
    idle(1);

    // zero-wait read ch0
    clr_obs();
    txn(1'b0, 1'b0, 8'h10, 16'h0000, 0, 16'hBEEF, 1'b0);
    idle(1);
    chk("zw_done_cnt", 32'(obs_done), 1);
    chk("zw_strobe_cycles", 32'(obs_strb), 1);
    chk("zw_rdata", 32'(rdata), 32'hBEEF);

    // write ch1 with 3 wait states
    clr_obs();
    txn(1'b1, 1'b1, 8'h22, 16'h1234, 3, 16'hFFFF, 1'b0);
    idle(1);
    chk("wr_strobe_cycles", 32'(obs_strb), 4);
    chk("wr_done_cnt", 32'(obs_done), 1);
    chk("wr_rdata_kept", 32'(rdata), 32'hBEEF);
    chk("wr_addr", 32'(mem_addr), 32'h22);
    chk("wr_wdata", 32'(mem_wdata), 32'h1234);

    // timeout, no ack ever
    clr_obs();
    txn(1'b0, 1'b0, 8'h30, 16'h0000, -1, 16'h0BAD, 1'b0);
    idle(1);
    chk("to_strobe_cycles", 32'(obs_strb), 15);
    chk("to_err_cnt", 32'(obs_err), 1);
    chk("to_done_cnt", 32'(obs_done), 0);
    chk("to_rdata_kept", 32'(rdata), 32'hBEEF);

    // ack on the last permitted wait cycle beats the timeout
    clr_obs();
    txn(1'b0, 1'b1, 8'h40, 16'h0000, 14, 16'h0F0F, 1'b0);
    idle(1);
    chk("edge_strobe_cycles", 32'(obs_strb), 15);
    chk("edge_done_cnt", 32'(obs_done), 1);
    chk("edge_err_cnt", 32'(obs_err), 0);
    chk("edge_rdata", 32'(rdata), 32'h0F0F);

    // stray acks on ch0 and requests while busy
    clr_obs();
    txn(1'b0, 1'b1, 8'h55, 16'h0000, 2, 16'hC0DE, 1'b1);
    idle(1);
    chk("stray_done_cnt", 32'(obs_done), 1);
    chk("stray_err_cnt", 32'(obs_err), 0);
    chk("stray_strobe_cycles", 32'(obs_strb), 3);
    chk("stray_rdata", 32'(rdata), 32'hC0DE);

    // back-to-back at the minimum issue interval
    clr_obs();
    txn(1'b1, 1'b0, 8'h60, 16'hAAAA, 0, 16'h0000, 1'b0);
    txn(1'b0, 1'b0, 8'h61, 16'h0000, 1, 16'h6161, 1'b0);
    idle(1);
    chk("b2b_done_cnt", 32'(obs_done), 2);
    chk("b2b_rdata", 32'(rdata), 32'h6161);

    // reset in the middle of an access
    step();
    req = 1'b1; we = 1'b0; ch_sel = 1'b1; addr = 8'h44; wdata = 16'h0000;
    mem_idle();
    exp_idle();
    for (int j = 0; j < 2; j++) begin
      step();
      req = 1'b0;
      m_addr = 8'h44; m_wdata = 16'h0000;
      e_busy = 1'b1; e_done = 1'b0; e_err = 1'b0; e_rd = 2'b10; e_wr = '0;
    end
    step();
    chk("pre_rst_rd", 32'(mem_rd), 32'h2);
    rst_n = 1'b0;
    #1;
    chk("rst_async_rd", 32'(mem_rd), 0);
    chk("rst_async_busy", 32'(busy), 0);
    m_addr = '0; m_wdata = '0; m_rdata = '0;
    exp_idle();
    clr_obs();
    step();
    rst_n = 1'b1;
    idle(2);
    chk("rst_no_done", 32'(obs_done), 0);
    chk("rst_no_err", 32'(obs_err), 0);

    // normal read after reset
    clr_obs();
    txn(1'b0, 1'b1, 8'h70, 16'h0000, 1, 16'h4321, 1'b0);
    idle(2);
    chk("post_rst_done_cnt", 32'(obs_done), 1);
    chk("post_rst_rdata", 32'(rdata), 32'h4321);

    e_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, limit 200000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule
